led_effect_driver: RTL and testbench



---
 rtl/led_effect_driver.sv | 124 ++++++++++++
 tb/tb_led_effect_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_effect_driver.sv
// LED effect driver: registers the LED PIO value and controls, applies static,
// blink or rotating-chase effects on a programmable tick, then 16-level PWM dimming.
//   clk, reset     : clock, synchronous active-high reset
//   pattern_in     : LED pattern from the PIO
//   mode_in        : 0 static, 1 blink, 2 chase left, 3 chase right
//   brightness_in  : PWM duty n/16 (15 = fully on, 0 = off)
//   led_out        : registered LED drive, 1 = lit
//   tick_out       : one-cycle pulse per effect tick
module led_effect_driver #(
  parameter int WIDTH    = 10,
  parameter int TICK_DIV = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [1:0]       mode_in,
  input  logic [3:0]       brightness_in,
  output logic [WIDTH-1:0] led_out,
  output logic             tick_out
);

  typedef enum logic [1:0] {
    M_STATIC  = 2'd0,
    M_BLINK   = 2'd1,
    M_CHASE_L = 2'd2,
    M_CHASE_R = 2'd3
  } mode_e;

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] pat_prev_q, pat_prev_d;
  mode_e            mode_q, mode_d;
  mode_e            mode_prev_q, mode_prev_d;
  logic [3:0]       bri_q, bri_d;
  logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [3:0]       pwm_cnt_q, pwm_cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             tick_out_q, tick_out_d;

  logic             tick;
  logic             mode_chg;
  logic             pat_chg;
  logic             pwm_on;
  logic [WIDTH-1:0] effect;

  always_comb begin
    pat_d       = pattern_in;
    mode_d      = mode_e'(mode_in);
    bri_d       = brightness_in;
    pat_prev_d  = pat_q;
    mode_prev_d = mode_q;

    mode_chg = (mode_q != mode_prev_q);
    pat_chg  = (pat_q != pat_prev_q);
    tick     = (tick_cnt_q == TICK_LAST);

    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
    phase_d    = phase_q;
    work_d     = work_q;

    // A reload wins over a coincident tick so the new
    // pattern is shown unrotated for a full tick period.
    if (mode_chg) begin
      tick_cnt_d = '0;
      phase_d    = 1'b1;
      work_d     = pat_q;
    end else if (pat_chg) begin
      work_d = pat_q;
    end else if (tick) begin
      unique case (mode_q)
        M_STATIC:  work_d  = pat_q;
        M_BLINK:   phase_d = ~phase_q;
        M_CHASE_L: work_d  = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        M_CHASE_R: work_d  = {work_q[0], work_q[WIDTH-1:1]};
      endcase
    end

    effect = work_q;
    if (mode_q == M_BLINK && !phase_q) begin
      effect = '0;
    end

    pwm_cnt_d  = pwm_cnt_q + 4'd1;
    pwm_on     = (bri_q == 4'hF) || (pwm_cnt_q < bri_q);
    led_d      = pwm_on ? effect : '0;
    tick_out_d = tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q       <= '0;
      pat_prev_q  <= '0;
      mode_q      <= M_STATIC;
      mode_prev_q <= M_STATIC;
      bri_q       <= '0;
      tick_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      phase_q     <= 1'b1;
      work_q      <= '0;
      led_q       <= '0;
      tick_out_q  <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      pat_prev_q  <= pat_prev_d;
      mode_q      <= mode_d;
      mode_prev_q <= mode_prev_d;
      bri_q       <= bri_d;
      tick_cnt_q  <= tick_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      phase_q     <= phase_d;
      work_q      <= work_d;
      led_q       <= led_d;
      tick_out_q  <= tick_out_d;
    end
  end

  assign led_out  = led_q;
  assign tick_out = tick_out_q;

endmodule

// File: tb/tb_led_effect_driver.sv
// Testbench for led_effect_driver: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_led_effect_driver;

  localparam int W  = 10;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pattern_in;
  logic [1:0]   mode_in;
  logic [3:0]   brightness_in;
  logic [W-1:0] led_out;
  logic         tick_out;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  led_effect_driver #(
    .WIDTH   (W),
    .TICK_DIV(TD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_in   (pattern_in),
    .mode_in      (mode_in),
    .brightness_in(brightness_in),
    .led_out      (led_out),
    .tick_out     (tick_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state described as "cycles since reset",
  // "cycles since last effect restart" and the current shown word.
  int m_pat, m_mode, m_bri, p_pat, p_mode;
  int m_since, m_cyc, m_work, m_led;
  bit m_phase, m_tick;
  int eff;
  bit mchg, pchg, tk, lit;

  always @(posedge clk) begin
    if (reset) begin
      m_pat = 0; m_mode = 0; m_bri = 0;
      p_pat = 0; p_mode = 0;
      m_since = 0; m_cyc = 0;
      m_phase = 1'b1; m_work = 0;
      m_led = 0; m_tick = 1'b0;
    end else begin
      mchg = (m_mode != p_mode);
      pchg = (m_pat != p_pat);
      tk   = ((m_since % TD) == TD - 1);
      eff  = (m_mode == 1 && !m_phase) ? 0 : m_work;
      lit  = (m_bri == 15) || ((m_cyc % 16) < m_bri);
      m_led  = lit ? eff : 0;
      m_tick = tk;
      if (mchg) begin
        m_since = 0;
        m_phase = 1'b1;
        m_work  = m_pat;
      end else begin
        m_since++;
        if (pchg) m_work = m_pat;
        else if (tk) begin
          case (m_mode)
            0: m_work = m_pat;
            1: m_phase = !m_phase;
            2: m_work = ((m_work * 2) | (m_work >> (W - 1))) & 'h3FF;
            default: m_work = (m_work >> 1) | ((m_work & 1) << (W - 1));
          endcase
        end
      end
      m_cyc++;
      p_pat  = m_pat;
      p_mode = m_mode;
      m_pat  = int'(pattern_in);
      m_mode = int'(mode_in);
      m_bri  = int'(brightness_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_led", int'(led_out), m_led);
      check("model_tick", int'(tick_out), int'(m_tick));
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_out && n < 40);
    if (!tick_out) check("tick_timeout", n, -1);
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  int n;
  int on_cnt, off_cnt;
  int chase_exp [3] = '{'h003, 'h006, 'h00C};

  initial begin
    reset = 1'b1;
    pattern_in = 10'h3FF;
    mode_in = 2'd0;
    brightness_in = 4'd15;
    @(posedge clk);
    chk_en = 1'b1;

    // 1: reset held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_led", int'(led_out), 0);
      check("rst_tick", int'(tick_out), 0);
    end

    // 2: static latency
    pattern_in = 10'h000;
    reset = 1'b0;
    idle(5);
    check("static_zero", int'(led_out), 0);
    pattern_in = 10'h2A5;
    idle(2);
    check("static_edge2", int'(led_out), 0);
    idle(1);
    check("static_edge3", int'(led_out), 'h2A5);
    idle(4);
    check("static_steady", int'(led_out), 'h2A5);

    // 3: pwm duty 4/16
    pattern_in = 10'h3FF;
    brightness_in = 4'd4;
    idle(4);
    on_cnt = 0;
    off_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led_out == 10'h3FF) on_cnt++;
      if (led_out == 10'h000) off_cnt++;
    end
    check("pwm_on_cnt", on_cnt, 4);
    check("pwm_off_cnt", off_cnt, 12);

    // 4: blink
    brightness_in = 4'd15;
    mode_in = 2'd1;
    pattern_in = 10'h00F;
    idle(3);
    wait_tick(n);
    wait_tick(n);
    check("tick_period", n, 4);
    check("blink_off", int'(led_out), 0);
    idle(1);
    check("blink_on", int'(led_out), 'h00F);

    // 5: chase left then right
    mode_in = 2'd2;
    pattern_in = 10'h201;
    idle(3);
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      idle(1);
      check("chase_l", int'(led_out), chase_exp[k]);
    end
    mode_in = 2'd3;
    idle(3);
    wait_tick(n);
    idle(1);
    check("chase_r", int'(led_out), 'h300);

    // 6: reload beats tick, then reset
    mode_in = 2'd2;
    idle(3);
    wait_tick(n);
    idle(2);
    mode_in = 2'd0;
    idle(2);
    check("reload_tick", int'(tick_out), 1);
    idle(1);
    check("reload_norot", int'(led_out), 'h201);
    reset = 1'b1;
    idle(1);
    check("mid_rst_led", int'(led_out), 0);
    reset = 1'b0;
    wait_tick(n);
    check("post_rst_tick", n, 4);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
